// File: rtl/priority_encoder_pkg.sv
// priority_encoder_pkg: shared defaults and a highest-set-bit helper for the
// priority encoder and any block that needs a leading-one index.
package priority_encoder_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_YW    = 3;

    // Index of the highest set bit of v; 0 when v is all zeros, so callers
    // must qualify the result with |v.
    function automatic logic [DEF_YW-1:0] hsb_index(input logic [DEF_WIDTH-1:0] v);
        logic [DEF_YW-1:0] r;
        logic              found;
        r     = '0;
        found = 1'b0;
        for (int i = DEF_WIDTH - 1; i >= 0; i--) begin
            if (!found && v[i]) begin
                r     = DEF_YW'(i);
                found = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/priority_encoder_core.sv
// priority_encoder_core: combinational highest-set-bit encoder.
//   d       in  WIDTH  request vector, bit WIDTH-1 has highest priority
//   idx     out YW     index of highest set bit (0 when d == 0)
//   any_set out 1      d is non-zero
module priority_encoder_core
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int YW    = DEF_YW
) (
    input  logic [WIDTH-1:0] d,
    output logic [YW-1:0]    idx,
    output logic             any_set
);

    logic found;

    // Scan from the top bit down; the first hit wins and masks lower bits.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!found && d[i]) begin
                idx   = YW'(i);
                found = 1'b1;
            end
        end
        any_set = found;
    end

endmodule

// File: rtl/priority_encoder_8x3.sv
// priority_encoder_8x3: registered priority encoder, one cycle of latency.
//   clk   in  1      system clock
//   rst_n in  1      asynchronous active-low reset
//   en    in  1      sample enable; outputs hold when low
//   d     in  WIDTH  request vector, bit WIDTH-1 has highest priority
//   y     out YW     registered index of highest set bit of d
//   valid out 1      registered; sampled d was non-zero
module priority_encoder_8x3
    import priority_encoder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int YW    = DEF_YW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [YW-1:0]    y,
    output logic             valid
);

    logic [YW-1:0] idx;
    logic          any_set;
    logic [YW-1:0] y_d, y_q;
    logic          valid_d, valid_q;

    priority_encoder_core #(.WIDTH(WIDTH), .YW(YW)) u_core (
        .d       (d),
        .idx     (idx),
        .any_set (any_set)
    );

    always_comb begin
        y_d     = en ? idx : y_q;
        valid_d = en ? any_set : valid_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
        end
    end

    assign y     = y_q;
    assign valid = valid_q;

endmodule

// File: tb/tb_priority_encoder_8x3.sv
// tb_priority_encoder_8x3: self-checking bench for priority_encoder_8x3.
module tb_priority_encoder_8x3;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] d;
    logic [2:0] y;
    logic       valid;

    int n_checks = 0;
    int n_fail   = 0;

    priority_encoder_8x3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .d     (d),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: floor(log2(v)) by repeated halving; 0 for v == 0.
    function automatic logic [2:0] ref_idx(input logic [7:0] v);
        int x;
        int r;
        x = int'(v);
        r = 0;
        while (x > 1) begin
            x = x / 2;
            r++;
        end
        return 3'(r);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        d     = 8'hFF;
        #1;
        n_checks++;
        if (y !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hold: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
        end
        tick();
        n_checks++;
        if (y !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_edge: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (y !== 3'd7 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: y=%0d valid=%0b, expected y=7 valid=1", y, valid);
        end
    endtask

    task automatic test_one_hot_walk();
        en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 8'd1 << i;
            tick();
            n_checks++;
            if (y !== 3'(i) || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL one_hot_%0d: y=%0d valid=%0b, expected y=%0d valid=1", i, y, valid, i);
            end
        end
    endtask

    task automatic test_multi_hot();
        logic [7:0] pats [3];
        logic [2:0] exp  [3];
        pats = '{8'b0101_0011, 8'b0000_0110, 8'b1111_1111};
        exp  = '{3'd6, 3'd2, 3'd7};
        en   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            d = pats[i];
            tick();
            n_checks++;
            if (y !== exp[i] || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL multi_hot d=%b: y=%0d valid=%0b, expected y=%0d valid=1", pats[i], y, valid, exp[i]);
            end
        end
    endtask

    task automatic test_zero();
        en = 1'b1;
        d  = 8'b0010_0000;
        tick();
        n_checks++;
        if (y !== 3'd5 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL zero_pre: y=%0d valid=%0b, expected y=5 valid=1", y, valid);
        end
        d = 8'h00;
        tick();
        n_checks++;
        if (y !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
        end
    endtask

    task automatic test_enable_hold();
        en = 1'b1;
        d  = 8'b0001_0000;
        tick();
        n_checks++;
        if (y !== 3'd4 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_capture: y=%0d valid=%0b, expected y=4 valid=1", y, valid);
        end
        en = 1'b0;
        d  = 8'b1000_0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++;
            if (y !== 3'd4 || valid !== 1'b1) begin
                n_fail++;
                $display("FAIL hold_cycle_%0d: y=%0d valid=%0b, expected y=4 valid=1", i, y, valid);
            end
        end
        en = 1'b1;
        tick();
        n_checks++;
        if (y !== 3'd7 || valid !== 1'b1) begin
            n_fail++;
            $display("FAIL hold_release: y=%0d valid=%0b, expected y=7 valid=1", y, valid);
        end
    endtask

    task automatic test_exhaustive();
        en = 1'b1;
        for (int v = 0; v < 256; v++) begin
            d = 8'(v);
            tick();
            n_checks++;
            if (y !== ref_idx(8'(v)) || valid !== (v != 0)) begin
                n_fail++;
                $display("FAIL exhaustive d=%02h: y=%0d valid=%0b, expected y=%0d valid=%0b",
                         v, y, valid, ref_idx(8'(v)), v != 0);
            end
        end
    endtask

    task automatic test_mid_reset();
        en = 1'b1;
        d  = 8'b0100_0000;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (y !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
        end
        tick();
        rst_n = 1'b1;
        en    = 1'b0;
        tick();
        n_checks++;
        if (y !== 3'd0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_pending: y=%0d valid=%0b, expected y=0 valid=0", y, valid);
        end
    endtask

    task automatic test_random();
        logic [2:0] exp_y;
        logic       exp_v;
        exp_y = y;
        exp_v = valid;
        for (int i = 0; i < 300; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            d  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) d = 8'h00;
            if (en) begin
                exp_y = ref_idx(d);
                exp_v = (d != 8'h00);
            end
            tick();
            d = 8'($urandom);
            n_checks++;
            if (y !== exp_y || valid !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: y=%0d valid=%0b, expected y=%0d valid=%0b", i, y, valid, exp_y, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_one_hot_walk();
        test_multi_hot();
        test_zero();
        test_enable_hold();
        test_exhaustive();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
